// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- definitions shared between the writeback unit, its load
// formatter and the register file.
//   RF_ADDR_WIDTH : default register index width (32 architectural registers)
//   RF_DATA_WIDTH : default register data width
//   load_funct3_e : RV32I load funct3 encodings
package rv32i_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if -- result sources feeding the writeback unit.
//   ALU side : i_alu_valid, o_alu_ready, i_alu_rd, i_alu_data
//   Load side: i_ld_valid, i_ld_rd, i_ld_rdata, i_ld_addr_lo, i_ld_funct3
//
// Handshake: an ALU result transfers on a rising clk edge where i_alu_valid
// and o_alu_ready are both high; the producer holds rd/data stable while
// valid is high and not yet accepted. The load side has no ready: a load
// response is consumed on every edge where i_ld_valid is high.
interface writeback_unit_if #(
  parameter int ADDR_WIDTH = rv32i_pkg::RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = rv32i_pkg::RF_DATA_WIDTH
) ();

  logic                  i_alu_valid;
  logic                  o_alu_ready;
  logic [ADDR_WIDTH-1:0] i_alu_rd;
  logic [DATA_WIDTH-1:0] i_alu_data;

  logic                  i_ld_valid;
  logic [ADDR_WIDTH-1:0] i_ld_rd;
  logic [DATA_WIDTH-1:0] i_ld_rdata;
  logic [1:0]            i_ld_addr_lo;
  logic [2:0]            i_ld_funct3;

  // Producers (execute stage / memory response path)
  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_ld_valid, i_ld_rd, i_ld_rdata, i_ld_addr_lo, i_ld_funct3,
    input  o_alu_ready
  );

  // Writeback unit
  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_ld_valid, i_ld_rd, i_ld_rdata, i_ld_addr_lo, i_ld_funct3,
    output o_alu_ready
  );

endinterface

// File: rtl/load_formatter.sv
// load_formatter -- combinational extraction of a load result from an
// aligned memory word.
//   i_rdata    : aligned memory word
//   i_addr_lo  : byte offset of the load address
//   i_funct3   : load type (load_funct3_e encodings)
//   o_data     : extracted, sign/zero-extended value
//   o_err      : load type illegal or access misaligned
module load_formatter
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_addr_lo,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword select uses only addr_lo[1]; addr_lo[0] set is flagged below.
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_funct3)
      LD_LB:  o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LD_LBU: o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      LD_LH: begin
        if (i_addr_lo[0]) o_err = 1'b1;
        else              o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      end
      LD_LHU: begin
        if (i_addr_lo[0]) o_err = 1'b1;
        else              o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      end
      LD_LW: begin
        if (i_addr_lo != 2'b00) o_err = 1'b1;
        else                    o_data = i_rdata;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit -- arbitrates ALU results and load responses onto the
// single register-file write port.
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-low reset
//   bus          : ALU and load result sources (writeback_unit_if.slave)
//   o_we         : register-file write enable (registered)
//   o_wr_address : register-file write address (registered)
//   o_wr_data    : register-file write data (registered)
//   o_ld_err     : one-cycle pulse, illegal/misaligned load dropped
//   o_wr_count   : committed-write counter, wraps at 16 bits
//
// Loads always win the write slot. An ALU result that loses to a load is
// parked in a one-entry skid register and drains on the first cycle with
// no load; while parked, the ALU is back-pressured.
module writeback_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_unit_if.slave       bus,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_wr_address,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_ld_err,
  output logic [15:0]           o_wr_count
);

  logic                  r_skid_full;
  logic [ADDR_WIDTH-1:0] r_skid_rd;
  logic [DATA_WIDTH-1:0] r_skid_data;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wr_address;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_ld_err;
  logic [15:0]           r_wr_count;

  logic                  w_alu_hs;
  logic [DATA_WIDTH-1:0] w_fmt_data;
  logic                  w_fmt_err;
  logic                  w_sel_valid;
  logic [ADDR_WIDTH-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_ld_err;
  logic                  w_we;

  load_formatter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_formatter (
    .i_rdata   (bus.i_ld_rdata),
    .i_addr_lo (bus.i_ld_addr_lo),
    .i_funct3  (bus.i_ld_funct3),
    .o_data    (w_fmt_data),
    .o_err     (w_fmt_err)
  );

  // Ready is forced low while reset is asserted so nothing is accepted.
  assign bus.o_alu_ready = rst & ~r_skid_full;
  assign w_alu_hs        = bus.i_alu_valid & bus.o_alu_ready;

  // Source select: load > skid > direct ALU. An erroring load still
  // occupies the slot; it just produces no write.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    w_ld_err    = 1'b0;
    if (bus.i_ld_valid) begin
      w_sel_valid = ~w_fmt_err;
      w_sel_rd    = bus.i_ld_rd;
      w_sel_data  = w_fmt_data;
      w_ld_err    = w_fmt_err;
    end else if (r_skid_full) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_skid_rd;
      w_sel_data  = r_skid_data;
    end else if (w_alu_hs) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.i_alu_rd;
      w_sel_data  = bus.i_alu_data;
    end
  end

  // x0 writes are consumed silently.
  assign w_we = w_sel_valid & (w_sel_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_full <= 1'b0;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
    end else if (bus.i_ld_valid && w_alu_hs) begin
      r_skid_full <= 1'b1;
      r_skid_rd   <= bus.i_alu_rd;
      r_skid_data <= bus.i_alu_data;
    end else if (!bus.i_ld_valid && r_skid_full) begin
      r_skid_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we         <= 1'b0;
      r_wr_address <= '0;
      r_wr_data    <= '0;
      r_ld_err     <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      r_we     <= w_we;
      r_ld_err <= w_ld_err;
      // Address/data only move on a real write; otherwise they hold.
      if (w_we) begin
        r_wr_address <= w_sel_rd;
        r_wr_data    <= w_sel_data;
        r_wr_count   <= r_wr_count + 16'd1;
      end
    end
  end

  assign o_we         = r_we;
  assign o_wr_address = r_wr_address;
  assign o_wr_data    = r_wr_data;
  assign o_ld_err     = r_ld_err;
  assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit -- self-checking bench for writeback_unit.
module tb_writeback_unit;

  localparam int AW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  writeback_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  logic          o_we;
  logic [AW-1:0] o_wr_address;
  logic [DW-1:0] o_wr_data;
  logic          o_ld_err;
  logic [15:0]   o_wr_count;

  writeback_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .o_we         (o_we),
    .o_wr_address (o_wr_address),
    .o_wr_data    (o_wr_data),
    .o_ld_err     (o_ld_err),
    .o_wr_count   (o_wr_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ALU results wait in a queue of capacity one; a load
  // takes the slot whenever present, otherwise the oldest ALU result writes.
  logic [AW+DW-1:0] exp_q[$];
  logic             e_we;
  logic             e_err;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_data;
  logic [15:0]      e_count;

  function automatic void ref_load(input logic [31:0] w, input logic [1:0] lo,
                                   input logic [2:0] f3, output logic [31:0] v,
                                   output logic err);
    int unsigned sh;
    int unsigned b;
    int unsigned h;
    sh  = 8 * int'(lo);
    b   = (w >> sh) & 32'hFF;
    h   = (w >> sh) & 32'hFFFF;
    v   = 0;
    err = 0;
    case (f3)
      3'd0: v = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: v = b;
      3'd1: if (lo % 2 == 1) err = 1; else v = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: if (lo % 2 == 1) err = 1; else v = h;
      3'd2: if (lo != 0) err = 1; else v = w;
      default: err = 1;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    e_we = 0; e_err = 0; e_addr = '0; e_data = '0; e_count = '0;
  endtask

  task automatic model_step();
    logic [AW+DW-1:0] item;
    logic [31:0]      v;
    logic             err;
    e_we  = 0;
    e_err = 0;
    if (bus_if.i_alu_valid && exp_q.size() == 0)
      exp_q.push_back({bus_if.i_alu_rd, bus_if.i_alu_data});
    if (bus_if.i_ld_valid) begin
      ref_load(bus_if.i_ld_rdata, bus_if.i_ld_addr_lo, bus_if.i_ld_funct3, v, err);
      e_err = err;
      if (!err && bus_if.i_ld_rd != 0) begin
        e_we = 1; e_addr = bus_if.i_ld_rd; e_data = v;
      end
    end else if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      if (item[AW+DW-1:DW] != 0) begin
        e_we = 1; e_addr = item[AW+DW-1:DW]; e_data = item[DW-1:0];
      end
    end
    if (e_we) e_count = e_count + 16'd1;
  endtask

  task automatic check_model();
    check("we",    32'(o_we),               32'(e_we));
    check("addr",  32'(o_wr_address),       32'(e_addr));
    check("data",  o_wr_data,               e_data);
    check("ld_err", 32'(o_ld_err),          32'(e_err));
    check("count", 32'(o_wr_count),         32'(e_count));
    check("ready", 32'(bus_if.o_alu_ready), 32'(exp_q.size() == 0));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] lw,
                       input logic [1:0] lo, input logic [2:0] f3);
    bus_if.i_alu_valid  = av;
    bus_if.i_alu_rd     = ard;
    bus_if.i_alu_data   = ad;
    bus_if.i_ld_valid   = lv;
    bus_if.i_ld_rd      = lrd;
    bus_if.i_ld_rdata   = lw;
    bus_if.i_ld_addr_lo = lo;
    bus_if.i_ld_funct3  = f3;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, '0, 2'd0, 3'd0);
  endtask

  task automatic alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    cycle(1, rd, d, 0, '0, '0, 2'd0, 3'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } ld_vec_t;

  ld_vec_t vecs[15];

  initial begin
    logic [15:0] cnt0;

    vecs[0]  = '{3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 1'b0};
    vecs[2]  = '{3'b000, 2'd0, 32'h80FF_7F01, 32'h0000_0001, 1'b0};
    vecs[3]  = '{3'b000, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0};
    vecs[4]  = '{3'b000, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{3'b100, 2'd2, 32'h80FF_7F01, 32'h0000_00FF, 1'b0};
    vecs[6]  = '{3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001, 1'b0};
    vecs[7]  = '{3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 1'b0};
    vecs[8]  = '{3'b001, 2'd0, 32'h0001_8002, 32'hFFFF_8002, 1'b0};
    vecs[9]  = '{3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{3'b010, 2'd1, 32'h8001_0000, 32'h0,         1'b1};
    vecs[11] = '{3'b001, 2'd1, 32'h8001_0000, 32'h0,         1'b1};
    vecs[12] = '{3'b101, 2'd3, 32'h8001_0000, 32'h0,         1'b1};
    vecs[13] = '{3'b011, 2'd0, 32'h1111_2222, 32'h0,         1'b1};
    vecs[14] = '{3'b110, 2'd0, 32'h1111_2222, 32'h0,         1'b1};

    rst = 1'b0;
    bus_if.i_alu_valid = 0; bus_if.i_alu_rd = '0; bus_if.i_alu_data = '0;
    bus_if.i_ld_valid = 0; bus_if.i_ld_rd = '0; bus_if.i_ld_rdata = '0;
    bus_if.i_ld_addr_lo = '0; bus_if.i_ld_funct3 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    32'(o_we), 32'd0);
    check("rst_addr",  32'(o_wr_address), 32'd0);
    check("rst_data",  o_wr_data, 32'd0);
    check("rst_err",   32'(o_ld_err), 32'd0);
    check("rst_count", 32'(o_wr_count), 32'd0);
    check("rst_ready", 32'(bus_if.o_alu_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #6;

    // Single ALU write
    alu(5'd5, 32'h1234_5678);
    check("alu_we", 32'(o_we), 32'd1);
    check("alu_addr", 32'(o_wr_address), 32'd5);
    check("alu_data", o_wr_data, 32'h1234_5678);
    check("alu_count", 32'(o_wr_count), 32'd1);

    // Load and ALU collide: load first, ALU parked in skid
    cycle(1, 5'd4, 32'hA, 1, 5'd3, 32'h80FF_7F01, 2'd3, 3'b000);
    check("col_addr", 32'(o_wr_address), 32'd3);
    check("col_data", o_wr_data, 32'hFFFF_FF80);
    check("col_ready", 32'(bus_if.o_alu_ready), 32'd0);
    idle();
    check("skid_addr", 32'(o_wr_address), 32'd4);
    check("skid_data", o_wr_data, 32'hA);
    check("skid_ready", 32'(bus_if.o_alu_ready), 32'd1);

    // Load formatter table
    for (int i = 0; i < 15; i++) begin
      cycle(0, '0, '0, 1, 5'd9, vecs[i].rdata, vecs[i].lo, vecs[i].f3);
      check($sformatf("vec%0d_we", i), 32'(o_we), 32'(!vecs[i].exp_err));
      check($sformatf("vec%0d_err", i), 32'(o_ld_err), 32'(vecs[i].exp_err));
      if (!vecs[i].exp_err) check($sformatf("vec%0d_data", i), o_wr_data, vecs[i].exp_data);
    end
    idle();

    // x0 destination
    cnt0 = o_wr_count;
    alu(5'd0, 32'hDEAD_BEEF);
    check("x0_we", 32'(o_we), 32'd0);
    check("x0_count", 32'(o_wr_count), 32'(cnt0));

    // Skid full plus three back-to-back loads; ALU keeps offering
    cnt0 = o_wr_count;
    cycle(1, 5'd12, 32'hCAFE_0001, 1, 5'd20, 32'h0000_0011, 2'd0, 3'b010);
    cycle(1, 5'd13, 32'h0BAD_0002, 1, 5'd21, 32'h0000_0022, 2'd0, 3'b010);
    check("starve_ready", 32'(bus_if.o_alu_ready), 32'd0);
    cycle(1, 5'd13, 32'h0BAD_0002, 1, 5'd22, 32'h0000_0033, 2'd0, 3'b010);
    check("starve_addr", 32'(o_wr_address), 32'd22);
    idle();
    check("drain_addr", 32'(o_wr_address), 32'd12);
    check("drain_data", o_wr_data, 32'hCAFE_0001);
    check("drain_count", 32'(o_wr_count), 32'(cnt0 + 16'd4));

    // Reset while the skid holds an entry
    cycle(1, 5'd7, 32'h7777_7777, 1, 5'd8, 32'h8888_8888, 2'd0, 3'b010);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_we", 32'(o_we), 32'd0);
    check("mrst_addr", 32'(o_wr_address), 32'd0);
    check("mrst_data", o_wr_data, 32'd0);
    check("mrst_count", 32'(o_wr_count), 32'd0);
    check("mrst_ready", 32'(bus_if.o_alu_ready), 32'd0);
    model_reset();
    bus_if.i_alu_valid = 0; bus_if.i_ld_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    #6;
    idle();
    check("post_rst_we", 32'(o_we), 32'd0);
    idle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : ((($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000)
                                          | 3'($urandom_range(0, 2)));
      cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom(),
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)), $urandom(),
            2'($urandom_range(0, 3)), f3);
    end
    idle();

    // Counter wrap: restart from reset, then 0x10000 writes
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #6;
    for (int i = 0; i < 65535; i++) alu(5'd1, 32'(i));
    check("count_max", 32'(o_wr_count), 32'h0000_FFFF);
    alu(5'd2, 32'h5A5A_5A5A);
    check("count_wrap", 32'(o_wr_count), 32'd0);
    check("wrap_we", 32'(o_we), 32'd1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register index width (32 architectural registers).
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 i_alu_valid  input  1  ALU result offered.
REQ-006 o_alu_ready  output  1  ALU result accepted when valid and ready are both high on a clk edge.
REQ-007 i_alu_rd  input  ADDR_WIDTH  ALU destination register.
REQ-008 i_alu_data  input  DATA_WIDTH  ALU result.
REQ-009 i_ld_valid  input  1  load response offered; always accepted, no ready.
REQ-010 i_ld_rd  input  ADDR_WIDTH  load destination register.
REQ-011 i_ld_rdata  input  DATA_WIDTH  aligned memory word.
REQ-012 i_ld_addr_lo  input  2  byte offset of load address.
REQ-013 i_ld_funct3  input  3  load type.
REQ-014 o_we  output  1  register-file write enable, registered.
REQ-015 o_wr_address  output  ADDR_WIDTH  register-file write address, registered.
REQ-016 o_wr_data  output  DATA_WIDTH  register-file write data, registered.
REQ-017 o_ld_err  output  1  one-cycle pulse: illegal or misaligned load dropped.
REQ-018 o_wr_count  output  16  committed-write counter, wraps at 0xFFFF -> 0x0000.

Function
REQ-019 Latency SHALL be exactly one cycle from acceptance to o_we/o_wr_address/o_wr_data.
REQ-020 At most one write SHALL be issued per cycle; load response has priority over any ALU result.
REQ-021 A one-entry ALU skid register SHALL exist; o_alu_ready SHALL equal NOT skid_full (0 while rst low).
REQ-022 Load valid AND ALU handshake in the same cycle: load writes, ALU result captured in skid.
REQ-023 Skid full, no load valid: skid entry writes, skid empties; no new ALU accept that cycle.
REQ-024 Skid full, load valid: load writes, skid holds unchanged (ALU may starve under back-to-back loads; accepted).
REQ-025 Skid empty, no load, ALU handshake: ALU result writes directly, skid untouched.
REQ-026 Any selected result with rd == 0 SHALL be consumed with o_we = 0 and o_wr_count unchanged.
REQ-027 funct3 000 LB, 100 LBU: byte at offset addr_lo, sign- / zero-extended to DATA_WIDTH.
REQ-028 funct3 001 LH, 101 LHU: halfword at offset addr_lo (0 or 2), sign- / zero-extended.
REQ-029 funct3 010 LW: full word, addr_lo SHALL be 0.
REQ-030 Other funct3, LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0: load consumed, o_we = 0, o_ld_err = 1 next cycle.
REQ-031 An erroring load still takes priority over ALU/skid in its cycle (slot lost, not reused).
REQ-032 o_wr_count SHALL increment by 1 on each cycle o_we = 1.
REQ-033 When no source is selected, o_we SHALL be 0; o_wr_address/o_wr_data hold previous values.

Reset
REQ-034 On rst low, asynchronously: o_we=0, o_wr_address=0, o_wr_data=0, o_ld_err=0, o_wr_count=0, skid empty.
REQ-035 Reset mid-operation SHALL discard skid contents and any in-flight write; no write issued on the first edge after release unless a source is valid.

Structure
REQ-036 Load funct3 encodings (enum), ADDR_WIDTH/DATA_WIDTH defaults shared with the register file SHALL live in rv32i_pkg.
REQ-037 Load extraction SHALL be a purely combinational sub-module load_formatter (rdata, addr_lo, funct3 -> data, err).

Verification
REQ-038 ALU rd=5 data=0x1234_5678 valid one cycle, no load -> next cycle o_we=1, addr=5, data=0x1234_5678, count=1.
REQ-039 Load LB rd=3 rdata=0x80FF_7F01 addr_lo=3 same cycle as ALU rd=4 data=0xA -> cycle+1 write r3=0xFFFF_FF80; cycle+2 write r4=0xA; o_alu_ready low during cycle+1.
REQ-040 Loads LHU addr_lo=2 rdata=0x8001_0000 rd=7 -> r7=0x0000_8001; LH same -> 0xFFFF_8001; LW addr_lo=1 -> o_ld_err pulse, o_we=0.
REQ-041 ALU rd=0 data=0xDEAD_BEEF -> o_we stays 0, o_wr_count unchanged.
REQ-042 Skid full plus 3 consecutive loads -> 3 load writes, then skid write on 4th cycle; count +4.
REQ-043 Assert rst low with skid full mid-stream -> all outputs 0 immediately, skid empty, o_alu_ready=1 after release, 0xFFFF+1 writes wrap count to 0.
